// File: rtl/wb_2to1_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter.
// m0 (LSU) and m1 (instruction fetch) share one slave port. A grant lasts for
// the owner's whole cyc. Accepted-but-unacked requests are counted so ownership
// only moves once the slave has answered everything it accepted.
module wb_2to1_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,   // 1..15
    parameter int PRIORITY        = 0    // 0 round-robin, 1 fixed (m0 wins)
) (
    input  logic                    port0_wb_clk_i,
    input  logic                    port0_wb_rst_i,

    input  logic                    m0_wb_cyc_i,
    input  logic                    m0_wb_stb_i,
    input  logic                    m0_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
    output logic                    m0_wb_stall_o,
    output logic                    m0_wb_ack_o,
    output logic                    m0_wb_err_o,
    output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,

    input  logic                    m1_wb_cyc_i,
    input  logic                    m1_wb_stb_i,
    input  logic                    m1_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
    output logic                    m1_wb_stall_o,
    output logic                    m1_wb_ack_o,
    output logic                    m1_wb_err_o,
    output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,

    output logic                    s_wb_cyc_o,
    output logic                    s_wb_stb_o,
    output logic                    s_wb_we_o,
    output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
    output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
    input  logic                    s_wb_stall_i,
    input  logic                    s_wb_ack_i,
    input  logic                    s_wb_err_i,
    input  logic [DATA_WIDTH-1:0]   s_wb_dat_i
);

    localparam int NUM_M = 2;
    localparam int SW    = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  cyc;
        logic                  stb;
        logic                  we;
        logic [ADDR_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0] dat;
        logic [SW-1:0]         sel;
    } wb_req_t;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

    state_t                 state, state_next;
    logic [3:0]             cnt, cnt_next;
    logic                   last;          // master granted most recently
    logic                   full, cnt_nz;
    logic                   accept, resp;
    logic                   own_idx;
    logic [NUM_M-1:0]       own_vec;
    logic [NUM_M-1:0]       mcyc;
    wb_req_t [NUM_M-1:0]    req;
    wb_req_t                sel_req;
    logic [NUM_M-1:0]       m_stall, m_ack, m_err;

    assign req[0] = {m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i, m0_wb_adr_i, m0_wb_dat_i, m0_wb_sel_i};
    assign req[1] = {m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i, m1_wb_adr_i, m1_wb_dat_i, m1_wb_sel_i};
    assign mcyc   = {req[1].cyc, req[0].cyc};

    // Winner when arbitrating from IDLE/DRAIN: a lone requester wins outright;
    // a tie goes to m0 in fixed mode, otherwise to whoever was not served last.
    function automatic logic pick(input logic [1:0] c, input logic lst);
        if (c == 2'b11)
            return (PRIORITY != 0) ? 1'b0 : ~lst;
        return c[1] & ~c[0];
    endfunction

    assign full   = (cnt == 4'(MAX_OUTSTANDING));
    assign cnt_nz = (cnt != 4'd0);

    // A response with nothing outstanding (e.g. a straggler after reset) is
    // not counted and never forwarded.
    assign accept = s_wb_stb_o & ~s_wb_stall_i;
    assign resp   = (s_wb_ack_i | s_wb_err_i) & cnt_nz;

    // Outstanding-count next value; accept and response together cancel.
    always_comb begin
        cnt_next = cnt;
        if (accept && !resp)
            cnt_next = cnt + 4'd1;
        else if (!accept && resp)
            cnt_next = cnt - 4'd1;
    end

    // State register.
    always_ff @(posedge port0_wb_clk_i) begin
        if (port0_wb_rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Outstanding counter.
    always_ff @(posedge port0_wb_clk_i) begin
        if (port0_wb_rst_i)
            cnt <= 4'd0;
        else
            cnt <= cnt_next;
    end

    // Remember who was granted last; reset value 1 lets m0 win the first tie.
    always_ff @(posedge port0_wb_clk_i) begin
        if (port0_wb_rst_i)
            last <= 1'b1;
        else if (state_next == OWN0 && state != OWN0)
            last <= 1'b0;
        else if (state_next == OWN1 && state != OWN1)
            last <= 1'b1;
    end

    // Next-state: hand over directly when the other master waits, drain the
    // slave if the owner aborts with responses still pending.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|mcyc)
                    state_next = pick(mcyc, last) ? OWN1 : OWN0;
            end
            OWN0, OWN1: begin
                if (!sel_req.cyc) begin
                    if (cnt_next != 4'd0)
                        state_next = DRAIN;
                    else if (mcyc[~own_idx])
                        state_next = own_idx ? OWN0 : OWN1;
                    else
                        state_next = IDLE;
                end
            end
            DRAIN: begin
                if (cnt_next == 4'd0)
                    state_next = (|mcyc) ? (pick(mcyc, last) ? OWN1 : OWN0) : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs: who owns the bus and the slave cyc/stb.
    always_comb begin
        own_idx    = 1'b0;
        own_vec    = '0;
        s_wb_cyc_o = 1'b0;
        s_wb_stb_o = 1'b0;
        case (state)
            OWN0: begin
                own_vec[0] = 1'b1;
                s_wb_cyc_o = req[0].cyc;
                s_wb_stb_o = req[0].stb & ~full;
            end
            OWN1: begin
                own_idx    = 1'b1;
                own_vec[1] = 1'b1;
                s_wb_cyc_o = req[1].cyc;
                s_wb_stb_o = req[1].stb & ~full;
            end
            DRAIN: begin
                s_wb_cyc_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Request payload follows the owner (m0 when nobody owns; stb is low then).
    assign sel_req    = req[own_idx];
    assign s_wb_we_o  = sel_req.we;
    assign s_wb_adr_o = sel_req.adr;
    assign s_wb_dat_o = sel_req.dat;
    assign s_wb_sel_o = sel_req.sel;

    // Per-master response gating: only the owner sees the slave handshake.
    for (genvar g = 0; g < NUM_M; g++) begin : g_rsp
        assign m_stall[g] = ~own_vec[g] | s_wb_stall_i | full;
        assign m_ack[g]   = own_vec[g] & cnt_nz & s_wb_ack_i;
        assign m_err[g]   = own_vec[g] & cnt_nz & s_wb_err_i;
    end

    assign m0_wb_stall_o = m_stall[0];
    assign m0_wb_ack_o   = m_ack[0];
    assign m0_wb_err_o   = m_err[0];
    assign m0_wb_dat_o   = s_wb_dat_i;
    assign m1_wb_stall_o = m_stall[1];
    assign m1_wb_ack_o   = m_ack[1];
    assign m1_wb_err_o   = m_err[1];
    assign m1_wb_dat_o   = s_wb_dat_i;

endmodule

// File: tb/tb_wb_2to1_arbiter.sv
// Bench for wb_2to1_arbiter: directed scenarios plus a randomized run, all
// checked against a transaction-level model of ownership and outstanding count.
module tb_wb_2to1_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_cyc[2], m_stb[2], m_we[2];
    logic [31:0] m_adr[2], m_dat[2];
    logic [3:0]  m_sel[2];
    logic        s_stall, s_ack, s_err;
    logic [31:0] s_rdat;

    logic        w_stall[2], w_ack[2], w_err[2];
    logic [31:0] w_rdat[2];
    logic        w_scyc, w_sstb, w_swe;
    logic [31:0] w_sadr, w_sdat;
    logic [3:0]  w_ssel;

    logic        p_stall[2], p_ack[2], p_err[2];
    logic [31:0] p_rdat[2];
    logic        p_scyc, p_sstb, p_swe;
    logic [31:0] p_sadr, p_sdat;
    logic [3:0]  p_ssel;

    int errors = 0;
    int checks = 0;

    // model: owner (-1 = none), drain flag, outstanding count, last granted
    int mo_own, mo_cnt, mo_last;
    bit mo_drain;
    int nx_own, nx_cnt, nx_last;
    bit nx_drain;

    always #5 clk = ~clk;

    wb_2to1_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO), .PRIORITY(0)) dut (
        .port0_wb_clk_i(clk), .port0_wb_rst_i(rst),
        .m0_wb_cyc_i(m_cyc[0]), .m0_wb_stb_i(m_stb[0]), .m0_wb_we_i(m_we[0]),
        .m0_wb_adr_i(m_adr[0]), .m0_wb_dat_i(m_dat[0]), .m0_wb_sel_i(m_sel[0]),
        .m0_wb_stall_o(w_stall[0]), .m0_wb_ack_o(w_ack[0]), .m0_wb_err_o(w_err[0]), .m0_wb_dat_o(w_rdat[0]),
        .m1_wb_cyc_i(m_cyc[1]), .m1_wb_stb_i(m_stb[1]), .m1_wb_we_i(m_we[1]),
        .m1_wb_adr_i(m_adr[1]), .m1_wb_dat_i(m_dat[1]), .m1_wb_sel_i(m_sel[1]),
        .m1_wb_stall_o(w_stall[1]), .m1_wb_ack_o(w_ack[1]), .m1_wb_err_o(w_err[1]), .m1_wb_dat_o(w_rdat[1]),
        .s_wb_cyc_o(w_scyc), .s_wb_stb_o(w_sstb), .s_wb_we_o(w_swe),
        .s_wb_adr_o(w_sadr), .s_wb_dat_o(w_sdat), .s_wb_sel_o(w_ssel),
        .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err), .s_wb_dat_i(s_rdat)
    );

    wb_2to1_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO), .PRIORITY(1)) dutp (
        .port0_wb_clk_i(clk), .port0_wb_rst_i(rst),
        .m0_wb_cyc_i(m_cyc[0]), .m0_wb_stb_i(m_stb[0]), .m0_wb_we_i(m_we[0]),
        .m0_wb_adr_i(m_adr[0]), .m0_wb_dat_i(m_dat[0]), .m0_wb_sel_i(m_sel[0]),
        .m0_wb_stall_o(p_stall[0]), .m0_wb_ack_o(p_ack[0]), .m0_wb_err_o(p_err[0]), .m0_wb_dat_o(p_rdat[0]),
        .m1_wb_cyc_i(m_cyc[1]), .m1_wb_stb_i(m_stb[1]), .m1_wb_we_i(m_we[1]),
        .m1_wb_adr_i(m_adr[1]), .m1_wb_dat_i(m_dat[1]), .m1_wb_sel_i(m_sel[1]),
        .m1_wb_stall_o(p_stall[1]), .m1_wb_ack_o(p_ack[1]), .m1_wb_err_o(p_err[1]), .m1_wb_dat_o(p_rdat[1]),
        .s_wb_cyc_o(p_scyc), .s_wb_stb_o(p_sstb), .s_wb_we_o(p_swe),
        .s_wb_adr_o(p_sadr), .s_wb_dat_o(p_sdat), .s_wb_sel_o(p_ssel),
        .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err), .s_wb_dat_i(s_rdat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input bit prio, input int lst);
        if (m_cyc[0] && m_cyc[1])
            return prio ? 0 : ((lst == 0) ? 1 : 0);
        return m_cyc[0] ? 0 : 1;
    endfunction

    // Check the round-robin DUT against the model for this cycle's inputs and
    // work out what the model looks like after the coming edge.
    task automatic settle();
        int n;
        int ncnt;
        bit full, acc, rsp;
        logic e_scyc, e_sstb;
        logic e_stall[2], e_ack[2], e_err[2];
        #1;
        full = (mo_cnt == MAXO);
        for (int i = 0; i < 2; i++) begin
            e_stall[i] = 1'b1; e_ack[i] = 1'b0; e_err[i] = 1'b0;
        end
        if (mo_own >= 0) begin
            n = mo_own;
            e_scyc     = m_cyc[n];
            e_sstb     = m_stb[n] && !full;
            e_stall[n] = s_stall || full;
            e_ack[n]   = s_ack && (mo_cnt > 0);
            e_err[n]   = s_err && (mo_cnt > 0);
            chk("s_we",  w_swe,  m_we[n]);
            chk("s_adr", w_sadr, m_adr[n]);
            chk("s_dat", w_sdat, m_dat[n]);
            chk("s_sel", w_ssel, m_sel[n]);
        end else begin
            e_scyc = mo_drain;
            e_sstb = 1'b0;
        end
        chk("s_cyc", w_scyc, e_scyc);
        chk("s_stb", w_sstb, e_sstb);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d_stall", i), w_stall[i], e_stall[i]);
            chk($sformatf("m%0d_ack", i),   w_ack[i],   e_ack[i]);
            chk($sformatf("m%0d_err", i),   w_err[i],   e_err[i]);
            chk($sformatf("m%0d_rdat", i),  w_rdat[i],  s_rdat);
        end

        acc  = e_sstb && !s_stall;
        rsp  = (s_ack || s_err) && (mo_cnt > 0);
        ncnt = mo_cnt + int'(acc) - int'(rsp);
        nx_own = mo_own; nx_drain = mo_drain; nx_last = mo_last; nx_cnt = ncnt;
        if (rst) begin
            nx_own = -1; nx_drain = 0; nx_cnt = 0; nx_last = 1;
        end else if (mo_own >= 0) begin
            if (!m_cyc[mo_own]) begin
                if (ncnt != 0) begin
                    nx_own = -1; nx_drain = 1;
                end else if (m_cyc[1-mo_own]) begin
                    nx_own = 1 - mo_own; nx_last = nx_own;
                end else begin
                    nx_own = -1;
                end
            end
        end else if (ncnt == 0) begin
            nx_drain = 0;
            if (m_cyc[0] || m_cyc[1]) begin
                nx_own = winner(1'b0, mo_last); nx_last = nx_own;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mo_own = nx_own; mo_drain = nx_drain; mo_cnt = nx_cnt; mo_last = nx_last;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0; m_stb[i] = 0; m_we[i] = 0;
            m_adr[i] = 0; m_dat[i] = 0; m_sel[i] = 4'hf;
        end
        s_stall = 0; s_ack = 0; s_err = 0; s_rdat = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) begin
            nx_own = -1; nx_drain = 0; nx_cnt = 0; nx_last = 1;
            tick();
        end
        rst = 0;
    endtask

    initial begin
        int acc;
        rst = 1;
        idle_inputs();
        @(negedge clk);

        // reset state
        do_reset();
        settle();
        chk("rst_s_cyc", w_scyc, 1'b0);
        chk("rst_s_stb", w_sstb, 1'b0);
        chk("rst_m0_stall", w_stall[0], 1'b1);
        chk("rst_m1_stall", w_stall[1], 1'b1);
        chk("rst_m0_ack", w_ack[0], 1'b0);
        tick();

        // 1: single m0 read at 0x10
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h10;
        settle(); chk("t1_idle_stall", w_stall[0], 1'b1); tick();
        settle();
        chk("t1_s_cyc", w_scyc, 1'b1);
        chk("t1_s_adr", w_sadr, 32'h10);
        chk("t1_m0_stall", w_stall[0], 1'b0);
        chk("t1_m1_stall", w_stall[1], 1'b1);
        tick();
        m_stb[0] = 0; s_ack = 1; s_rdat = 32'hCAFE0010;
        settle();
        chk("t1_ack", w_ack[0], 1'b1);
        chk("t1_rdat", w_rdat[0], 32'hCAFE0010);
        chk("t1_m1_stall_b", w_stall[1], 1'b1);
        tick();
        s_ack = 0; m_cyc[0] = 0;
        settle(); tick();
        settle(); chk("t1_idle_again", w_scyc, 1'b0); tick();

        // 2: simultaneous requests, m0 first, then direct handover
        do_reset();
        m_cyc[0] = 1; m_cyc[1] = 1; m_adr[1] = 32'h200;
        settle(); tick();
        settle();
        chk("t2_m0_grant", w_stall[0], 1'b0);
        chk("t2_m1_wait", w_stall[1], 1'b1);
        tick();
        m_cyc[0] = 0;
        settle(); tick();
        settle();
        chk("t2_m1_grant", w_stall[1], 1'b0);
        chk("t2_no_bubble", w_scyc, 1'b1);
        chk("t2_adr_m1", w_sadr, 32'h200);
        tick();
        m_cyc[1] = 0;
        settle(); tick();

        // 3: outstanding limit with slave ack held low
        do_reset();
        m_cyc[0] = 1; m_stb[0] = 1;
        settle(); tick();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            m_adr[0] = 32'h100 + 32'(i*4);
            settle();
            if (w_sstb === 1'b1 && !s_stall) acc++;
            if (i >= 4) begin
                chk("t3_full_stall", w_stall[0], 1'b1);
                chk("t3_full_stb", w_sstb, 1'b0);
            end
            tick();
        end
        chk("t3_accepted", acc, 4);
        s_ack = 1;
        settle(); chk("t3_ack_while_full", w_ack[0], 1'b1); tick();
        s_ack = 0;
        settle();
        chk("t3_fifth_stb", w_sstb, 1'b1);
        chk("t3_fifth_stall", w_stall[0], 1'b0);
        tick();
        m_cyc[0] = 0; m_stb[0] = 0; s_ack = 1;
        repeat (5) begin settle(); tick(); end
        s_ack = 0;
        settle(); chk("t3_drained", w_scyc, 1'b0); tick();

        // 4: abort with two pending -> drain, absorb acks, then m1
        do_reset();
        m_cyc[0] = 1; m_stb[0] = 1;
        repeat (3) begin settle(); tick(); end
        m_cyc[0] = 0; m_stb[0] = 0; m_cyc[1] = 1;
        settle(); tick();
        s_ack = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t4_drain_cyc", w_scyc, 1'b1);
            chk("t4_drain_stb", w_sstb, 1'b0);
            chk("t4_m0_ack", w_ack[0], 1'b0);
            chk("t4_m1_ack", w_ack[1], 1'b0);
            chk("t4_m1_stall", w_stall[1], 1'b1);
            tick();
        end
        s_ack = 0;
        settle(); chk("t4_own1", w_stall[1], 1'b0); tick();
        m_cyc[1] = 0;
        settle(); tick();

        // 5: reset mid-burst with three outstanding
        do_reset();
        m_cyc[0] = 1; m_stb[0] = 1;
        repeat (4) begin settle(); tick(); end
        rst = 1;
        settle(); tick();
        rst = 0; m_cyc[0] = 0; m_stb[0] = 0; s_ack = 1;
        settle();
        chk("t5_s_cyc", w_scyc, 1'b0);
        chk("t5_late_ack", w_ack[0], 1'b0);
        tick();
        m_cyc[0] = 1; m_cyc[1] = 1; s_ack = 0;
        settle(); tick();
        s_ack = 1;
        settle();
        chk("t5_tie_m0", w_stall[0], 1'b0);
        chk("t5_tie_m1", w_stall[1], 1'b1);
        chk("t5_cnt_zero", w_ack[0], 1'b0);
        tick();
        s_ack = 0; m_cyc[0] = 0; m_cyc[1] = 0;
        settle(); tick();

        // 6: fixed priority instance
        do_reset();
        for (int k = 0; k < 3; k++) begin
            m_cyc[0] = 1; m_cyc[1] = 1;
            settle(); tick();
            settle();
            chk("t6_prio_m0", p_stall[0], 1'b0);
            chk("t6_prio_m1", p_stall[1], 1'b1);
            tick();
            m_cyc[0] = 0; m_cyc[1] = 0;
            settle(); tick();
        end
        m_cyc[1] = 1;
        settle(); tick();
        settle(); chk("t6_m1_alone", p_stall[1], 1'b0); tick();
        m_cyc[1] = 0;
        settle(); tick();

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_cyc[i]) m_cyc[i] = ($urandom_range(99, 0) < 30);
                else           m_cyc[i] = ($urandom_range(99, 0) >= 15);
                m_stb[i] = m_cyc[i] && ($urandom_range(1, 0) == 1);
                m_we[i]  = $urandom_range(1, 0) == 1;
                m_adr[i] = $urandom;
                m_dat[i] = $urandom;
                m_sel[i] = 4'($urandom_range(15, 0));
            end
            s_stall = ($urandom_range(99, 0) < 25);
            s_ack   = ($urandom_range(99, 0) < 35);
            s_err   = !s_ack && ($urandom_range(99, 0) < 10);
            s_rdat  = $urandom;
            rst     = ($urandom_range(99, 0) < 1);
            settle(); tick();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
